// File: rtl/dm_pkg.sv
// Shared constants for the data-memory arbiter slice.
//   DM_AW/DM_DW   : address/data width presented to the data memory
//   DM_DEPTH      : physical depth of the single-ported data memory
//   DM_MAX_WAIT   : default denial limit before port 1 is force-granted
//   DM_CNT_W      : width of the port 1 wait counter
//   PORT_CPU/DISP : requester port indices
package dm_pkg;

  localparam int unsigned DM_AW       = 13;
  localparam int unsigned DM_DW       = 16;
  localparam int unsigned DM_DEPTH    = 2048;
  localparam int unsigned DM_MAX_WAIT = 4;
  localparam int unsigned DM_CNT_W    = 4;
  localparam int unsigned PORT_CPU    = 0;
  localparam int unsigned PORT_DISP   = 1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter.
//   req/we/addr/wdata : request payload, held stable until gnt
//   gnt               : access performed this cycle (combinational)
//   rvalid            : rdata carries this port's read result (registered)
//   rdata             : shared read data
// master = requesters, slave = arbiter.
interface dm_arbiter_if
  import dm_pkg::*;
#(
  parameter int unsigned AW = DM_AW,
  parameter int unsigned DW = DM_DW
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );

endinterface

// File: rtl/dm_starve_ctr.sv
// Port 1 starvation guard: counts consecutive denied cycles of port 1,
// raises force_c once the limit is reached and pulses starve_evt the
// cycle after a forced grant that actually overrode port 0.
//   clk, rst_n  : clock, async active-low reset
//   req0, req1  : requests (already reset-qualified by the parent)
//   gnt1        : port 1 grant this cycle
//   force_c     : port 1 must win this cycle (combinational)
//   starve_evt  : one-cycle registered pulse
module dm_starve_ctr
  import dm_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DM_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic gnt1,
  output logic force_c,
  output logic starve_evt
);

  localparam int unsigned CNT_W = DM_CNT_W;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             starve_evt_q, starve_evt_d;

  // Saturating denial counter and force pulse.
  always_comb begin
    wait_cnt_d   = '0;
    force_c      = req1 & (wait_cnt_q >= CNT_W'(MAX_WAIT));
    starve_evt_d = force_c & gnt1 & req0;
    if (req1 && !gnt1) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      starve_evt_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      starve_evt_q <= starve_evt_d;
    end
  end

  assign starve_evt = starve_evt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory. Port 0
// (CPU) has priority; port 1 (display fetch) is force-granted after
// MAX_WAIT consecutive denials. Grants and memory drive are combinational
// (memory samples on the falling edge), read-valid strobes are registered.
//   clk, rst_n  : clock, async active-low reset
//   bus         : requester bundle (slave side)
//   dm_re/dm_we : memory read/write enables
//   dm_addr     : memory address, zero when idle
//   dm_wdata    : memory write data, zero when idle
//   dm_rd_data  : memory read data, passed through to bus.rdata
//   starve_evt  : pulse after a forced grant to port 1
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned AW       = DM_AW,
  parameter int unsigned DW       = DM_DW,
  parameter int unsigned MAX_WAIT = DM_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arbiter_if.slave   bus,
  output logic          dm_re,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rd_data,
  output logic          starve_evt
);

  logic req0_c, req1_c;
  logic gnt0_c, gnt1_c;
  logic force_c;
  logic we_sel_c;
  logic rvalid0_q, rvalid0_d;
  logic rvalid1_q, rvalid1_d;

  // Requests are masked while in reset so the memory stays idle.
  assign req0_c = bus.req0 & rst_n;
  assign req1_c = bus.req1 & rst_n;

  dm_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0_c),
    .req1       (req1_c),
    .gnt1       (gnt1_c),
    .force_c    (force_c),
    .starve_evt (starve_evt)
  );

  // Grant, memory mux and next read-valid tags.
  always_comb begin
    gnt1_c    = req1_c & (~req0_c | force_c);
    gnt0_c    = req0_c & ~gnt1_c;
    we_sel_c  = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    if (gnt1_c) begin
      we_sel_c = bus.we1;
      dm_addr  = bus.addr1;
      dm_wdata = bus.wdata1;
    end else if (gnt0_c) begin
      we_sel_c = bus.we0;
      dm_addr  = bus.addr0;
      dm_wdata = bus.wdata0;
    end
    dm_re     = (gnt0_c | gnt1_c) & ~we_sel_c;
    dm_we     = (gnt0_c | gnt1_c) &  we_sel_c;
    rvalid0_d = gnt0_c & ~bus.we0;
    rvalid1_d = gnt1_c & ~bus.we1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign bus.gnt0    = gnt0_c;
  assign bus.gnt1    = gnt1_c;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = dm_rd_data;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by
// constrained-random traffic, all compared against a cycle-level model
// built from the arbitration rules, a reference memory image and a
// falling-edge memory model that drives dm_rd_data.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int unsigned AW       = DM_AW;
  localparam int unsigned DW       = DM_DW;
  localparam int          MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dm_re, dm_we, starve_evt;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rd_data;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dm_re      (dm_re),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rd_data (dm_rd_data),
    .starve_evt (starve_evt)
  );

  always #5 clk = ~clk;

  // Physical memory: one access on each falling edge.
  logic [DW-1:0] phys_mem [DM_DEPTH];
  always @(negedge clk) begin
    if (dm_we) phys_mem[dm_addr[10:0]] <= dm_wdata;
    if (dm_re) dm_rd_data <= phys_mem[dm_addr[10:0]];
  end

  // Reference model state.
  int            n_cmp = 0;
  int            n_err = 0;
  int            denied;
  logic [DW-1:0] ref_mem [DM_DEPTH];
  bit            exp_rv0, exp_rv1, exp_st;
  logic [DW-1:0] exp_rd;
  bit            mdl_g0, mdl_g1;
  logic          obs_g0, obs_g1, obs_rv0, obs_rv1, obs_st;
  logic [DW-1:0] obs_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_p0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic set_p1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic model_reset();
    denied = 0; exp_rv0 = 0; exp_rv1 = 0; exp_st = 0; mdl_g0 = 0; mdl_g1 = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, advances
  // the model and returns at the next posedge+1.
  task automatic tick();
    bit            e_g0, e_g1, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #1;
    e_g1   = bus.req1 && (!bus.req0 || denied >= MAX_WAIT);
    e_g0   = bus.req0 && !e_g1;
    e_we   = e_g1 ? bus.we1 : (e_g0 ? bus.we0 : 1'b0);
    e_addr = e_g1 ? bus.addr1 : (e_g0 ? bus.addr0 : '0);
    e_wd   = e_g1 ? bus.wdata1 : (e_g0 ? bus.wdata0 : '0);
    obs_g0 = bus.gnt0; obs_g1 = bus.gnt1; obs_rv0 = bus.rvalid0; obs_rv1 = bus.rvalid1;
    obs_st = starve_evt; obs_rd = bus.rdata;
    chk("gnt0", 32'(bus.gnt0), 32'(e_g0));
    chk("gnt1", 32'(bus.gnt1), 32'(e_g1));
    chk("dm_re", 32'(dm_re), 32'((e_g0 || e_g1) && !e_we));
    chk("dm_we", 32'(dm_we), 32'((e_g0 || e_g1) && e_we));
    chk("dm_addr", 32'(dm_addr), 32'(e_addr));
    chk("dm_wdata", 32'(dm_wdata), 32'(e_wd));
    chk("rvalid0", 32'(bus.rvalid0), 32'(exp_rv0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(exp_rv1));
    chk("starve_evt", 32'(starve_evt), 32'(exp_st));
    if (exp_rv0 || exp_rv1) chk("rdata", 32'(bus.rdata), 32'(exp_rd));
    exp_st  = e_g1 && bus.req0;
    exp_rv0 = e_g0 && !bus.we0;
    exp_rv1 = e_g1 && !bus.we1;
    if (e_g0 || e_g1) begin
      if (e_we) ref_mem[e_addr[10:0]] = e_wd;
      else      exp_rd = ref_mem[e_addr[10:0]];
    end
    denied = (bus.req1 && !e_g1) ? ((denied < 15) ? denied + 1 : 15) : 0;
    mdl_g0 = e_g0; mdl_g1 = e_g1;
    @(posedge clk); #1;
  endtask

  initial begin
    int            cnt, idx;
    logic [DW-1:0] v;
    dm_rd_data = '0;
    rst_n = 1'b0;
    for (int i = 0; i < int'(DM_DEPTH); i++) begin
      v = DW'($urandom);
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    model_reset();

    // Outputs idle while held in reset, even with requests raised.
    set_p0(1, 0, 13'h001, '0);
    set_p1(1, 1, 13'h002, 16'h1234);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_dm_re", 32'(dm_re), 0);
    chk("rst_dm_we", 32'(dm_we), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 0);
    chk("rst_starve", 32'(starve_evt), 0);
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0);
    rst_n = 1'b1;
    model_reset();

    // Port 0 write, then port 1 reads the same address.
    set_p0(1, 1, 13'h005, 16'hBEEF);
    tick();
    chk("wr_gnt0", 32'(obs_g0), 1);
    set_p0(0, 0, '0, '0);
    set_p1(1, 0, 13'h005, '0);
    tick();
    chk("rd_gnt1", 32'(obs_g1), 1);
    set_p1(0, 0, '0, '0);
    tick();
    chk("rd_rvalid1", 32'(obs_rv1), 1);
    chk("rd_rvalid0", 32'(obs_rv0), 0);
    chk("rd_rdata", 32'(obs_rd), 32'h0000_BEEF);

    // Continuous contention: port 1 wins once per 5-cycle window.
    set_p0(1, 0, 13'h020, '0);
    set_p1(1, 0, 13'h030, '0);
    cnt = 0; idx = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (obs_g1) begin cnt++; if (idx < 0) idx = i; end
    end
    chk("starve_share", 32'(cnt), 3);
    chk("starve_first", 32'(idx), 4);
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0);
    tick();
    chk("starve_pulse_after_window", 32'(obs_st), 1);

    // Alternating reads, no contention: one rvalid per cycle.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_p0(1, 0, 13'h010, '0); set_p1(0, 0, '0, '0); end
      else            begin set_p0(0, 0, '0, '0);       set_p1(1, 0, 13'h7FF, '0); end
      tick();
      if (i > 0 && (obs_rv0 ^ obs_rv1)) cnt++;
    end
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0);
    tick();
    if (obs_rv0 ^ obs_rv1) cnt++;
    chk("alt_rvalid_count", 32'(cnt), 8);

    // Dropping req1 restarts the wait count.
    set_p0(1, 0, 13'h040, '0);
    set_p1(1, 0, 13'h050, '0);
    for (int i = 0; i < 3; i++) tick();
    set_p1(0, 0, '0, '0);
    tick();
    set_p1(1, 0, 13'h050, '0);
    idx = -1;
    for (int i = 0; i < 8 && idx < 0; i++) begin
      tick();
      if (obs_g1) idx = i;
    end
    chk("restart_delay", 32'(idx), 4);
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0);

    // Idle for 20 cycles.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i > 0 && (obs_rv0 || obs_rv1 || obs_g0 || obs_g1)) cnt++;
    end
    chk("idle_activity", 32'(cnt), 0);
    chk("idle_wait_cnt", 32'(dut.u_starve.wait_cnt_q), 0);

    // Reset pulled low in the middle of a granted read.
    set_p0(1, 0, 13'h010, '0);
    #1;
    chk("mid_gnt0", 32'(bus.gnt0), 1);
    chk("mid_dm_re", 32'(dm_re), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_gnt0_drop", 32'(bus.gnt0), 0);
    chk("mid_dm_re_drop", 32'(dm_re), 0);
    @(posedge clk); #2;
    chk("mid_rvalid0", 32'(bus.rvalid0), 0);
    chk("mid_dm_addr", 32'(dm_addr), 0);
    chk("mid_gnt0_held", 32'(bus.gnt0), 0);
    @(posedge clk); #1;
    chk("mid_rvalid0_late", 32'(bus.rvalid0), 0);
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("post_rst_gnt0", 32'(obs_g0), 1);
    set_p0(0, 0, '0, '0);
    tick();
    chk("post_rst_rvalid0", 32'(obs_rv0), 1);

    // Random traffic obeying the hold-until-grant rule.
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0 || mdl_g0)
        set_p0($urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom), DW'($urandom));
      else if ($urandom_range(0, 99) < 5)
        bus.req0 = 1'b0;
      if (!bus.req1 || mdl_g1)
        set_p1($urandom_range(0, 99) < 60, 1'($urandom), AW'($urandom), DW'($urandom));
      else if ($urandom_range(0, 99) < 5)
        bus.req1 = 1'b0;
      tick();
    end
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter in front of the single-ported 2K x 16 data memory. The memory is read-or-write, one access per cycle, and accesses on clock fall.
- Port 0 is the CPU data port. Port 1 is the bitmap/display fetch engine.
- Port 0 has priority, with starvation protection for port 1. The block drives the memory's re/we/addr/wrt_data and returns tagged read-valid strobes.

Parameters:
- AW, 13, address width presented to the data memory.
- DW, 16, data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it is force-granted (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 access request (level; held until gnt0).
- we0  in  1  port 0 write (1) / read (0) qualifier.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access performed this cycle (combinational).
- rvalid0  out  1  rdata holds port 0 read result (registered).
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1.
- rdata  out  DW  shared read data, passed through from dm_rd_data.
- dm_re  out  1  to memory re.
- dm_we  out  1  to memory we.
- dm_addr  out  AW  to memory addr.
- dm_wdata  out  DW  to memory wrt_data.
- dm_rd_data  in  DW  from memory rd_data.
- starve_evt  out  1  one-cycle pulse when a forced grant to port 1 occurs.

Behaviour:
- **Grant logic (combinational, same cycle):**
  - force = req1 & (wait_cnt >= MAX_WAIT).
  - gnt1 = req1 & (~req0 | force).
  - gnt0 = req0 & ~gnt1.
  - At most one grant per cycle.
- **Memory drive:**
  - dm_re = gnt_any & ~we_sel; dm_we = gnt_any & we_sel.
  - dm_re and dm_we are never both 1.
  - dm_addr/dm_wdata come from the granted port's mux; they are all-zero when no grant.
  - The memory samples on the falling edge of the grant cycle.
- **wait_cnt (4-bit register):**
  - Cleared on reset, and whenever gnt1 or ~req1.
  - Incremented when req1 & ~gnt1, saturating at 15.
- **starve_evt:** registered pulse; asserted in the cycle after a grant where force=1 and req0=1.
- **Read return:**
  - rvalid0 <= gnt0 & ~we0; rvalid1 <= gnt1 & ~we1.
  - rvalid is high exactly in the cycle after the granted read; rdata = dm_rd_data in that cycle.
  - Writes produce no rvalid.
- **Latency:** grant 0 cycles from req; read data 1 cycle after grant.
  - Back-to-back reads from either or both ports return one per cycle.
  - The tags always match grant order.
- **Requester rule:** a requester holds req/we/addr/wdata stable until it sees gnt. Deasserting req without a grant cancels the request, with no side effects.
- **Simultaneous requests:** port 0 wins unless force is set.
  - A write by one port followed next cycle by a read of the same address from the other port returns the new data (memory ordering is preserved).
- **Reset (asynchronous, at any time, including mid-access):**
  - Immediately: gnt0 = gnt1 = 0, dm_re = dm_we = 0, rvalid0 = rvalid1 = 0, starve_evt = 0, wait_cnt = 0.
  - An in-flight read's rvalid is dropped.
  - Outputs stay idle while rst_n = 0, regardless of req inputs.

Decomposition:
- Shared package dm_pkg holds:
  - DM_AW = 13, DM_DW = 16, DM_DEPTH = 2048;
  - port index constants PORT_CPU = 0, PORT_DISP = 1.
- One natural sub-module: dm_starve_ctr, the saturating wait counter plus force compare and starve_evt pulse. The grant/mux/rvalid logic stays in dm_arbiter.

Test Plan:
- Reset, then req0 = 1, we0 = 1, addr0 = 0x005, wdata0 = 0xBEEF -> gnt0 = 1, dm_we = 1, dm_addr = 0x005 the same cycle. Then req1 read of 0x005 -> gnt1 = 1, next cycle rvalid1 = 1, rdata = 0xBEEF, rvalid0 = 0.
- req0 and req1 both held continuously as reads, MAX_WAIT = 4 -> gnt0 for 4 cycles, then gnt1 on the 5th cycle with starve_evt pulsing the following cycle, then gnt0 resumes.
  - Continue the pattern: port 1 gets exactly one grant per 5-cycle window.
- Alternating reads to 0x010 (port 0) and 0x7FF (port 1), no contention -> one rvalid per cycle, tag matches issuing port, data matches preloaded values, dm_re = 1 and dm_we = 0 throughout.
- req1 held 3 cycles while req0 is busy, then req1 dropped, then req1 re-raised -> wait_cnt restarts at 0, so the forced grant arrives only after 4 further denied cycles.
- Port 0 read granted, then rst_n pulled low mid-cycle -> rvalid0 never asserts, dm_re = 0 immediately, and all outputs stay 0 until rst_n = 1. The first request after reset is granted normally.
- No requests for 20 cycles -> dm_re = dm_we = 0, dm_addr = 0, no rvalid, wait_cnt = 0.
